// File: rtl/lin_recur_seq_gen_if.sv
// Request/stream bundle for the linear-recurrence sequence generator.
interface lin_recur_seq_gen_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) ();

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [WIDTH-1:0] seed2;
  logic [CNT_W-1:0] num_terms;
  logic             sat_en;
  logic [WIDTH-1:0] seq_o;
  logic             seq_valid;
  logic             seq_ready;
  logic             seq_last;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, mode, seed0, seed1, seed2, num_terms, sat_en, seq_ready,
    input  seq_o, seq_valid, seq_last, busy, done, ovf
  );

  modport slave (
    input  start, mode, seed0, seed1, seed2, num_terms, sat_en, seq_ready,
    output seq_o, seq_valid, seq_last, busy, done, ovf
  );

endinterface

// File: rtl/lin_recur_seq_gen.sv
// Fibonacci/Tribonacci-type term generator with valid/ready output stream,
// optional saturation and a sticky overflow flag.
module lin_recur_seq_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  lin_recur_seq_gen_if.slave bus
);

  localparam int unsigned SUM_W = WIDTH + 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_c;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_c_nxt;
  logic [CNT_W-1:0] r_remain, w_remain_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_sat, w_sat_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ovf, w_ovf_nxt;

  logic [SUM_W-1:0] w_sum;
  logic             w_sum_ovf;
  logic [WIDTH-1:0] w_sum_val;
  logic             w_valid;
  logic             w_last;
  logic             w_hs;

  // Next-term sum with two guard bits; the third operand only joins in mode 1.
  assign w_sum     = SUM_W'(r_a) + SUM_W'(r_b) + (r_mode ? SUM_W'(r_c) : {SUM_W{1'b0}});
  assign w_sum_ovf = |w_sum[SUM_W-1:WIDTH];
  assign w_sum_val = (w_sum_ovf && r_sat) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

  assign w_valid = (r_state == S_RUN);
  assign w_last  = w_valid && (r_remain == CNT_W'(1));
  assign w_hs    = w_valid && bus.seq_ready;

  assign bus.seq_o     = r_a;
  assign bus.seq_valid = w_valid;
  assign bus.seq_last  = w_last;
  assign bus.busy      = w_valid;
  assign bus.done      = r_done;
  assign bus.ovf       = r_ovf;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath updates; the final handshake holds a/b/c so seq_o keeps its last term.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_c_nxt      = r_c;
    w_remain_nxt = r_remain;
    w_mode_nxt   = r_mode;
    w_sat_nxt    = r_sat;
    w_ovf_nxt    = r_ovf;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_ovf_nxt = 1'b0;
          if (bus.num_terms != '0) begin
            w_a_nxt      = bus.seed0;
            w_b_nxt      = bus.seed1;
            w_c_nxt      = bus.seed2;
            w_mode_nxt   = bus.mode;
            w_sat_nxt    = bus.sat_en;
            w_remain_nxt = bus.num_terms;
            w_state_nxt  = S_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_hs) begin
          w_remain_nxt = r_remain - CNT_W'(1);
          if (w_sum_ovf) w_ovf_nxt = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_a_nxt = r_b;
            if (r_mode) begin
              w_b_nxt = r_c;
              w_c_nxt = w_sum_val;
            end else begin
              w_b_nxt = w_sum_val;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_remain <= '0;
      r_mode   <= 1'b0;
      r_sat    <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_c      <= w_c_nxt;
      r_remain <= w_remain_nxt;
      r_mode   <= w_mode_nxt;
      r_sat    <= w_sat_nxt;
      r_done   <= w_done_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

endmodule

// File: doc/lin_recur_seq_gen.md
LIN_RECUR_SEQ_GEN -- requirements
Module: lin_recur_seq_gen

Interface
REQ-001 Parameter WIDTH, default 32: term width in bits; legal range >= 4.
REQ-002 Parameter CNT_W, default 16: width of the term-count field.
REQ-003 Clock clk; reset reset, asynchronous, active-high.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous active-high reset.
REQ-006 Port start  input  1  single-cycle request to begin a sequence; sampled in IDLE only.
REQ-007 Port mode  input  1  recurrence select: 0 = two-term sum (Fibonacci-type), 1 = three-term sum (Tribonacci-type).
REQ-008 Port seed0, seed1, seed2  input  WIDTH each  initial terms; seed2 is ignored when mode=0.
REQ-009 Port num_terms  input  CNT_W  number of terms to emit.
REQ-010 Port sat_en  input  1  1 = saturate sums at all-ones; 0 = wrap modulo 2^WIDTH.
REQ-011 Port seq_o  output  WIDTH  current term.
REQ-012 Port seq_valid  output  1  seq_o holds a term.
REQ-013 Port seq_ready  input  1  consumer accepts a term; handshake = seq_valid & seq_ready.
REQ-014 Port seq_last  output  1  current term is the final term.
REQ-015 Port busy  output  1  high while in RUN.
REQ-016 Port done  output  1  one-cycle pulse at sequence end.
REQ-017 Port ovf  output  1  sticky overflow flag.

Function
REQ-018 FSM states: IDLE and RUN; busy = (state==RUN); seq_valid = (state==RUN).
REQ-019 IDLE, start=1, num_terms!=0: capture mode, sat_en, and num_terms into remaining-count; load a=seed0, b=seed1, c=seed2; clear ovf; next state RUN.
REQ-020 IDLE, start=1, num_terms==0: remain IDLE, clear ovf, assert done for exactly the next cycle, never assert seq_valid.
REQ-021 seq_o = register a (registered output); the first term (seed0) is valid in the cycle after the start edge.
REQ-022 On each handshake, mode 0: a<=b, b<=a+b; mode 1: a<=b, b<=c, c<=a+b+c; remaining-count decrements by 1.
REQ-023 Emitted order is seed0, seed1, then sums for mode 0; seed0, seed1, seed2, then sums for mode 1.
REQ-024 With seq_valid=1 and seq_ready=0: seq_o, seq_last, and all internal state hold; no term is skipped or repeated.
REQ-025 seq_last = seq_valid & (remaining-count==1).
REQ-026 Handshake with seq_last=1: next state IDLE, seq_valid drops the next cycle, done pulses for exactly that one cycle, and seq_o holds its last value.
REQ-027 Sums are computed at WIDTH+2 bits; overflow = any bit above WIDTH-1 is set.
REQ-028 On overflow: sat_en=1 stores all-ones; sat_en=0 stores the low WIDTH bits. In both cases ovf is set, including for sums computed but never emitted.
REQ-029 ovf stays set until the next accepted start (REQ-019/020) or reset.
REQ-030 start in RUN is ignored; mode, seeds, sat_en, and num_terms changes in RUN have no effect.

Reset
REQ-031 reset=1 forces IDLE immediately. seq_o=0, seq_valid=0, seq_last=0, busy=0, done=0, ovf=0, internal registers and count = 0.
REQ-032 Reset mid-RUN abandons the sequence and emits no done pulse; the next start restarts from the seeds.

Verification
REQ-033 WIDTH=32, mode0, seeds 0/1, num_terms=10, ready=1 -> 0,1,1,2,3,5,8,13,21,34 on consecutive cycles; seq_last with 34; done one cycle later; ovf=0.
REQ-034 mode1, seeds 0/0/1, num_terms=8 -> 0,0,1,1,2,4,7,13; seq_last with 13.
REQ-035 Scenario REQ-033 with seq_ready toggled pseudo-randomly -> identical accepted sequence; seq_o stable while stalled.
REQ-036 WIDTH=8, mode0, seeds 0/1, num_terms=16, sat_en=0 -> ...,144,233,121,98; ovf rises the cycle after the 144 handshake. Same with sat_en=1 -> ...,144,233,255,255.
REQ-037 Boundary cases:
- num_terms=0 -> no seq_valid, single done pulse.
- start pulsed during RUN -> no effect on the sequence.
REQ-038 Assert reset during term 5 of REQ-033 -> all outputs 0 while reset is held; no done; a fresh start emits 0,1,1,... again.
